// File: rtl/cmp_pkg.sv
// Shared types for the branch-condition compare path.
// Condition codes must match the condition-select mux encoding.
package cmp_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [1:0] COND_NE = 2'b00;
    localparam logic [1:0] COND_EQ = 2'b01;
    localparam logic [1:0] COND_LE = 2'b10;
    localparam logic [1:0] COND_GT = 2'b11;

    typedef struct packed {
        logic ne;
        logic eq;
        logic le;
        logic gt;
    } flags_t;

endpackage

// File: rtl/chunk_compare.sv
// Combinational compare of one operand chunk.
// Signed only for the chunk holding the sign bit.
module chunk_compare #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             is_signed_chunk,
    output logic             gt,
    output logic             eq
);

    always_comb begin
        eq = (a == b);
        if (is_signed_chunk) begin
            gt = ($signed(a) > $signed(b));
        end else begin
            gt = (a > b);
        end
    end

endmodule

// File: rtl/compare_flag_unit.sv
// Iterative MSB-first comparator driving registered NE/EQ/LE/GT flags.
// Exits early on the first differing chunk; flags change only on done.
module compare_flag_unit
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             flags_valid,
    output logic             NE,
    output logic             EQ,
    output logic             LE,
    output logic             GT
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    flags_t           flags_q, flags_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] ch_a, ch_b;
    logic             ch_gt, ch_eq;

    assign ch_a = a_q[idx_q*CHUNK +: CHUNK];
    assign ch_b = b_q[idx_q*CHUNK +: CHUNK];

    chunk_compare #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a              (ch_a),
        .b              (ch_b),
        .is_signed_chunk(sgn_q && (idx_q == IDX_TOP)),
        .gt             (ch_gt),
        .eq             (ch_eq)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        flags_d = flags_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            flags_d = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_d     = A;
                        b_d     = B;
                        sgn_d   = is_signed;
                        idx_d   = IDX_TOP;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!ch_eq) begin
                        flags_d = '{ne: 1'b1, eq: 1'b0,
                                    le: !ch_gt, gt: ch_gt};
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else if (idx_q == '0) begin
                        flags_d = '{ne: 1'b0, eq: 1'b1,
                                    le: 1'b1, gt: 1'b0};
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            flags_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = done_q;
    assign flags_valid = valid_q;
    assign NE          = flags_q.ne;
    assign EQ          = flags_q.eq;
    assign LE          = flags_q.le;
    assign GT          = flags_q.gt;

endmodule

// File: tb/tb_compare_flag_unit.sv
// Self-checking bench for compare_flag_unit (WIDTH=32, CHUNK=8).
module tb_compare_flag_unit;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             clear = 1'b0;
    logic             is_signed = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             busy, done, flags_valid, NE, EQ, LE, GT;

    int checks   = 0;
    int failures = 0;

    compare_flag_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .clear      (clear),
        .is_signed  (is_signed),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .flags_valid(flags_valid),
        .NE         (NE),
        .EQ         (EQ),
        .LE         (LE),
        .GT         (GT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          m;
        logic        gt;
        logic        eq;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word relation, latency from leading equal bytes.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         input logic s, output int m,
                         output logic gt, output logic eq);
        logic [31:0] diff;
        int lz;
        eq = (a == b);
        gt = s ? ($signed(a) > $signed(b)) : (a > b);
        diff = a ^ b;
        if (diff == 0) begin
            m = NCHUNK;
        end else begin
            lz = 0;
            while (!diff[31]) begin
                diff = diff << 1;
                lz++;
            end
            m = 1 + lz / CHUNK;
        end
    endtask

    // Called from an idle or done cycle, #1 after a rising edge.
    task automatic run_cmp(input logic [31:0] a, input logic [31:0] b,
                           input logic s, input int em,
                           input logic egt, input logic eeq);
        logic [3:0] old;
        bit got;
        old = {NE, EQ, LE, GT};
        A = a;
        B = b;
        is_signed = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        is_signed = 1'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        got = 0;
        for (int n = 1; n <= NCHUNK + 2 && !got; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1;
                chk("latency", n, em);
            end else begin
                chk("flags_held", 32'({NE, EQ, LE, GT}), 32'(old));
            end
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        chk("flags", 32'({NE, EQ, LE, GT}),
            32'({!eeq, eeq, !egt, egt}));
        chk("flags_valid", 32'(flags_valid), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int m;
        logic gt, eq;
        logic [31:0] ra, rb;
        logic rs;
        bit seen;

        tbl[0] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 4, 1'b0, 1'b1};
        tbl[1] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1, 1'b0, 1'b0};
        tbl[2] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1, 1'b1, 1'b0};
        tbl[3] = '{32'h0000_0102, 32'h0000_0101, 1'b0, 4, 1'b1, 1'b0};
        tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1, 1'b0, 1'b0};
        tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1, 1'b1, 1'b0};

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(flags_valid), 32'd0);
        chk("rst_flags", 32'({NE, EQ, LE, GT}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_cmp(tbl[i].a, tbl[i].b, tbl[i].s,
                    tbl[i].m, tbl[i].gt, tbl[i].eq);
            @(posedge clk);
            #1;
            chk("done_one_cycle", 32'(done), 32'd0);
        end

        // Start pulsed mid-run is ignored; operands stay latched.
        A = 32'h0000_0001;
        B = 32'h0000_0000;
        is_signed = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        A = 32'h0;
        B = 32'h1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 0;
        for (int n = 0; n < 6 && !seen; n++) begin
            if (done) seen = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("ignored_start_done", 32'(seen), 32'd1);
        chk("ignored_start_gt", 32'({NE, EQ, LE, GT}), 32'b1001);
        @(posedge clk);
        #1;
        chk("ignored_start_idle", 32'(busy), 32'd0);

        // Clear aborts a running equal compare.
        A = 32'd7;
        B = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        A = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("clear_pre_busy", 32'(busy), 32'd1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_busy", 32'(busy), 32'd0);
        chk("clear_flags", 32'({NE, EQ, LE, GT}), 32'd0);
        chk("clear_valid", 32'(flags_valid), 32'd0);
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            if (done) seen = 1;
            @(posedge clk);
            #1;
        end
        chk("clear_no_done", 32'(seen), 32'd0);

        // Async reset mid-run, then back-to-back compares.
        run_cmp(32'h0000_0002, 32'h0000_0001, 1'b0, 4, 1'b1, 1'b0);
        A = 32'd3;
        B = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("amid_busy", 32'(busy), 32'd0);
        chk("amid_flags", 32'({NE, EQ, LE, GT}), 32'd0);
        chk("amid_valid", 32'(flags_valid), 32'd0);
        chk("amid_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_cmp(32'h1234_5678, 32'h1234_5678, 1'b1, 4, 1'b0, 1'b1);
        run_cmp(32'h0012_0000, 32'h0034_0000, 1'b0, 2, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = ra;
            for (int k = 0; k < NCHUNK; k++) begin
                if ($urandom_range(2) == 0) rb[k*CHUNK +: CHUNK] = 8'($urandom);
            end
            rs = 1'($urandom);
            model(ra, rb, rs, m, gt, eq);
            run_cmp(ra, rb, rs, m, gt, eq);
            if ($urandom_range(1) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
